// File: rtl/game_state_controller_pkg.sv
// Shared types and constants for the flappy-box game: FSM states, screen geometry, physics, painter colours.
package game_pkg;

    typedef enum logic [2:0] {
        RUN_WAIT_TICK = 3'd0,
        ISSUE         = 3'd1,
        WAIT_ACK      = 3'd2,
        UPDATE        = 3'd3,
        GAME_OVER     = 3'd4,
        RESTART       = 3'd5
    } state_t;

    localparam int SCREEN_W     = 160;
    localparam int FLOOR_Y      = 118;
    localparam int GAP_H        = 24;
    localparam int PIPE_SPEED   = 1;
    localparam int GRAVITY      = 1;
    localparam int FLAP_VEL     = -4;
    localparam int MAX_VEL      = 4;
    localparam int START_Y      = 60;
    localparam int PIPE_START_Y = 40;
    localparam int BOX_COL_LO   = 3;
    localparam int BOX_COL_HI   = 5;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    localparam logic [2:0] COL_SKY   = 3'd1;
    localparam logic [2:0] COL_BOX   = 3'd6;
    localparam logic [2:0] COL_PIPE  = 3'd2;
    localparam logic [2:0] COL_FLOOR = 3'd4;

    // Box is 3 rows tall (y-1..y+1) and must sit fully inside the gap rows py..py+GAP_H-1.
    function automatic logic collides(input logic [6:0] y, input logic [7:0] px, input logic [6:0] py);
        int y_i;
        int py_i;
        y_i  = int'(y);
        py_i = int'(py);
        return (px >= 8'(BOX_COL_LO)) && (px <= 8'(BOX_COL_HI)) &&
               ((y_i - 1 < py_i) || (y_i + 1 > py_i + GAP_H - 1));
    endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Game-to-painter signal bundle; the game controller is the master. Optional score field under SCORE_EN.
interface game_state_controller_if;
    logic       flap;
    logic       game_tick_after_draw;
    logic       game_pulse;
    logic [6:0] box_y;
    logic [7:0] pipe_one_x;
    logic [6:0] pipe_one_y;
    logic       game_over;
`ifdef SCORE_EN
    logic [7:0] score;
`endif

    // Handshake: master strobes game_pulse for one cycle; slave toggles game_tick_after_draw once the frame is drawn.
    modport master (
        input  flap, game_tick_after_draw,
        output game_pulse, box_y, pipe_one_x, pipe_one_y,
`ifdef SCORE_EN
        output score,
`endif
        output game_over
    );

    modport slave (
        output flap, game_tick_after_draw,
        input  game_pulse, box_y, pipe_one_x, pipe_one_y,
`ifdef SCORE_EN
        input  score,
`endif
        input  game_over
    );
endinterface

// File: rtl/game_state_controller_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to place pipe gaps; advances only when step is high.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] value
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else if (step) begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end
endmodule

// File: rtl/game_state_controller.sv
// Frame-rate game FSM driving the painter draw handshake, box physics and pipe motion.
// Optional SCORE_EN macro adds a saturating pipes-passed score output.
module game_state_controller
    import game_pkg::*;
#(
    parameter int FRAME_DIV = 833333
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    game_state_controller_if.master bus,
    output state_t                  dbg_state
);
    localparam int CW = $clog2(FRAME_DIV);
    localparam logic signed [7:0] VEL_FLAP = 8'(FLAP_VEL);
    localparam logic signed [7:0] VEL_MAX  = 8'(MAX_VEL);
    localparam logic signed [7:0] VEL_G    = 8'(GRAVITY);
    localparam logic signed [7:0] Y_FLOOR  = 8'(FLOOR_Y);

    state_t            state;
    logic [CW-1:0]     frame_cnt;
    logic              frame_tick;
    logic              flap_prev, flap_pend, flap_edge, flap_req;
    logic              ack_prev, ack_toggle;
    logic signed [7:0] vel, vel_next, y_sum;
    logic [6:0]        y_next, py_next;
    logic [7:0]        x_next, lfsr;
    logic              wrap, floor_hit, hit, dead;

    assign frame_tick = (frame_cnt == CW'(FRAME_DIV - 1));
    assign flap_edge  = bus.flap & ~flap_prev;
    assign flap_req   = flap_pend | flap_edge;
    assign ack_toggle = bus.game_tick_after_draw ^ ack_prev;
    assign dbg_state  = state;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) frame_cnt <= '0;
        else       frame_cnt <= frame_tick ? '0 : frame_cnt + CW'(1);
    end

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (CLOCK_50),
        .rst   (reset),
        .step  ((state == UPDATE) && wrap),
        .value (lfsr)
    );

    // Next-frame physics, evaluated from current registers and used only in UPDATE.
    always_comb begin
        vel_next = vel + VEL_G;
        if (flap_req)                    vel_next = VEL_FLAP;
        else if (vel >= VEL_MAX - VEL_G) vel_next = VEL_MAX;
        y_sum     = $signed({1'b0, bus.box_y}) + vel_next;
        y_next    = (y_sum < 8'sd1) ? 7'd1 : y_sum[6:0];
        floor_hit = (y_sum >= Y_FLOOR);
        wrap      = (bus.pipe_one_x < 8'(PIPE_SPEED));
        x_next    = wrap ? 8'(SCREEN_W - 1) : bus.pipe_one_x - 8'(PIPE_SPEED);
        py_next   = wrap ? 7'(8'd8 + (lfsr & 8'h3F)) : bus.pipe_one_y;
        hit       = collides(y_next, x_next, py_next);
        dead      = floor_hit | hit;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= RUN_WAIT_TICK;
            bus.game_pulse <= 1'b0;
            bus.box_y      <= 7'(START_Y);
            bus.pipe_one_x <= 8'(SCREEN_W - 1);
            bus.pipe_one_y <= 7'(PIPE_START_Y);
            bus.game_over  <= 1'b0;
            vel            <= '0;
            flap_prev      <= 1'b0;
            flap_pend      <= 1'b0;
            ack_prev       <= 1'b0;
`ifdef SCORE_EN
            bus.score      <= '0;
`endif
        end else begin
            flap_prev      <= bus.flap;
            // Tracking the ack level everywhere keeps stray toggles from triggering a later UPDATE.
            ack_prev       <= bus.game_tick_after_draw;
            bus.game_pulse <= 1'b0;
            if (flap_edge) flap_pend <= 1'b1;
            case (state)
                RUN_WAIT_TICK: begin
                    if (frame_tick) begin
                        state          <= ISSUE;
                        bus.game_pulse <= 1'b1;
                    end
                end
                ISSUE:    state <= WAIT_ACK;
                WAIT_ACK: if (ack_toggle) state <= UPDATE;
                UPDATE: begin
                    vel            <= vel_next;
                    flap_pend      <= 1'b0;
                    bus.box_y      <= y_next;
                    bus.pipe_one_x <= x_next;
                    bus.pipe_one_y <= py_next;
                    if (dead) begin
                        state         <= GAME_OVER;
                        bus.game_over <= 1'b1;
                    end else begin
                        state <= RUN_WAIT_TICK;
                    end
`ifdef SCORE_EN
                    if (wrap && !dead && bus.score != 8'hFF) bus.score <= bus.score + 8'd1;
`endif
                end
                GAME_OVER: begin
                    if (flap_edge) begin
                        state         <= RESTART;
                        bus.game_over <= 1'b0;
                    end
                end
                RESTART: begin
                    state          <= RUN_WAIT_TICK;
                    bus.box_y      <= 7'(START_Y);
                    bus.pipe_one_x <= 8'(SCREEN_W - 1);
                    bus.pipe_one_y <= 7'(PIPE_START_Y);
                    vel            <= '0;
                    flap_pend      <= 1'b0;
`ifdef SCORE_EN
                    bus.score      <= '0;
`endif
                end
                default: state <= RUN_WAIT_TICK;
            endcase
        end
    end
endmodule

// File: tb/tb_game_state_controller.sv
// Randomised bench for game_state_controller: driver plays the painter and the button, a rules model
// predicts each frame outcome into exp_q, and a monitor checks the DUT after every UPDATE/RESTART.
module tb_game_state_controller;
    import game_pkg::*;

    localparam int FD     = 16;
    localparam int FRAMES = 400;

    typedef struct {
        logic [6:0] y;
        logic [7:0] x;
        logic [6:0] py;
        logic       over;
        logic [7:0] score;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;
    exp_t   exp_q[$];
    int     total = 0;
    int     bad   = 0;

    // Reference model state, kept as plain integers.
    int       m_y, m_x, m_py, m_vel, m_score;
    bit       m_pend, m_over;
    bit [7:0] m_lfsr;
    int       life_mode;
    bit       first_over;

    always #5 clk = ~clk;

    game_state_controller_if bus();

    game_state_controller #(.FRAME_DIV(FD)) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    function automatic bit [7:0] lfsr_next(input bit [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.y     = 7'(m_y);
        e.x     = 8'(m_x);
        e.py    = 7'(m_py);
        e.over  = m_over;
        e.score = 8'(m_score);
        exp_q.push_back(e);
    endtask

    task automatic model_reset_positions();
        m_y = 60; m_x = 159; m_py = 40; m_vel = 0; m_pend = 0; m_score = 0; m_over = 0;
    endtask

    task automatic model_update();
        int  y;
        bit  wrap;
        m_vel  = m_pend ? -4 : ((m_vel + 1 > 4) ? 4 : m_vel + 1);
        m_pend = 0;
        y      = m_y + m_vel;
        m_over = (y >= 118);
        m_y    = (y < 1) ? 1 : y;
        wrap   = (m_x < 1);
        if (wrap) begin
            m_x    = 159;
            m_py   = 8 + (m_lfsr % 64);
            m_lfsr = lfsr_next(m_lfsr);
        end else begin
            m_x = m_x - 1;
        end
        if (m_x >= 3 && m_x <= 5 && ((m_y - 1 < m_py) || (m_y + 1 > m_py + 23))) m_over = 1;
        if (wrap && !m_over && m_score < 255) m_score++;
        push_expected();
    endtask

    function automatic bit decide_flap();
        int target;
        if (life_mode == 0) return 0;
        if (m_x >= 100 && m_x <= 124) target = 0;
        else if (m_x < 40)            target = m_py + 16;
        else                          target = 60;
        if (m_y > target) return ($urandom_range(0, 9) < 8);
        return ($urandom_range(0, 19) == 0);
    endfunction

    task automatic wait_pulse(output bit ok);
        ok = 0;
        for (int i = 0; i < 3 * FD + 8; i++) begin
            @(negedge clk);
            if (bus.game_pulse) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL pulse_timeout: got no game_pulse expected one within %0d cycles", 3 * FD + 8);
        end
    endtask

    task automatic game_over_phase();
        int n;
        int pulses;
        n          = first_over ? 100 * FD : 3 * FD;
        first_over = 0;
        pulses     = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.game_pulse) pulses++;
            if (i == 5 && $urandom_range(0, 1) == 1) bus.game_tick_after_draw = ~bus.game_tick_after_draw;
        end
        check("no_pulse_in_game_over", pulses, 0);
        check("game_over_held", int'(bus.game_over), 1);
        if (bus.flap) begin
            bus.flap = 0;
            @(negedge clk);
        end
        bus.flap = 1;
        model_reset_positions();
        push_expected();
        life_mode = $urandom_range(0, 3);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: outputs settle one cycle after an UPDATE or RESTART state.
    state_t last_st = RUN_WAIT_TICK;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (last_st == UPDATE || last_st == RESTART)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_update: got an update with no expected entry");
            end else begin
                e = exp_q.pop_front();
                if (bus.box_y !== e.y || bus.pipe_one_x !== e.x || bus.pipe_one_y !== e.py ||
                    bus.game_over !== e.over
`ifdef SCORE_EN
                    || bus.score !== e.score
`endif
                    ) begin
                    bad++;
                    $display("FAIL frame_result: got y=%0d x=%0d py=%0d over=%0d expected y=%0d x=%0d py=%0d over=%0d score=%0d",
                             bus.box_y, bus.pipe_one_x, bus.pipe_one_y, bus.game_over,
                             e.y, e.x, e.py, e.over, e.score);
                end
            end
        end
        last_st = dbg_state;
    end

    initial begin
        int  pulse_cnt;
        int  first_pulse;
        int  frames;
        bit  have_pulse;
        bit  ok;
        bit  abort;
        bit  want;

        bus.flap                 = 0;
        bus.game_tick_after_draw = 0;
        model_reset_positions();
        m_lfsr     = 8'hA5;
        life_mode  = 1;
        first_over = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_box_y", int'(bus.box_y), 60);
        check("reset_pipe_x", int'(bus.pipe_one_x), 159);
        check("reset_pipe_y", int'(bus.pipe_one_y), 40);
        check("reset_game_over", int'(bus.game_over), 0);
        check("reset_game_pulse", int'(bus.game_pulse), 0);
        rst = 0;

        // No ack yet: exactly one pulse at cycle 16, ticks in WAIT_ACK dropped.
        pulse_cnt   = 0;
        first_pulse = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.game_pulse) begin
                pulse_cnt++;
                if (first_pulse == 0) first_pulse = k;
            end
        end
        check("pulse_count_no_ack", pulse_cnt, 1);
        check("first_pulse_cycle", first_pulse, 16);
        check("box_y_before_ack", int'(bus.box_y), 60);

        frames     = 0;
        have_pulse = 1;
        abort      = 0;
        while (frames < FRAMES && !abort) begin
            if (!have_pulse) begin
                wait_pulse(ok);
                if (!ok) abort = 1;
            end
            if (!abort) begin
                have_pulse = 0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                want = decide_flap();
                if (frames < 5) want = 0;
                if (want) begin
                    if (bus.flap) begin
                        bus.flap = 0;
                        @(negedge clk);
                    end
                    bus.flap = 1;
                    m_pend   = 1;
                end else if ($urandom_range(0, 1) == 1) begin
                    bus.flap = 0;
                end
                repeat ($urandom_range(1, 3)) @(negedge clk);
                bus.game_tick_after_draw = ~bus.game_tick_after_draw;
                model_update();
                frames++;
                if (m_over) begin
                    repeat (3) @(negedge clk);
                    game_over_phase();
                end
            end
        end

        repeat (6) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 900000 ns");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
